div_seq_ctrl: RTL and testbench
===============================

Name: div_seq_ctrl

Overview:
- Sequencer between the CPU execute stage and the shared multicycle unsigned divider (N-bit restoring divider with enable/done handshake).
- Accepts RV32M DIV/DIVU/REM/REMU requests and converts signed operands to magnitudes. Handles divide-by-zero and signed overflow without using the divider.
- Pulses the divider start, waits for done, fixes the result sign, and holds the result until the pipeline consumes it.
- Supports pipeline flush by draining an in-flight divide and discarding its result.

Parameters:
- N, 32, operand/result width.
- TAG_W, 5, width of destination tag carried with each request.

Ports:
- clk  input  1  clock.
- rst  input  1  reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- req_a  input  N  dividend (rs1).
- req_b  input  N  divisor (rs2).
- req_tag  input  TAG_W  destination tag.
- flush  input  1  kill any request not yet delivered.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer takes result.
- resp_data  output  N  quotient or remainder.
- resp_tag  output  TAG_W  tag of the result.
- div_enable  output  1  divider start, one-cycle pulse.
- div_a  output  N  unsigned dividend to divider.
- div_b  output  N  unsigned divisor to divider.
- div_quot  input  N  divider quotient.
- div_rem  input  N  divider remainder.
- div_done  input  1  divider one-cycle completion pulse.

Behaviour:
- Reset: rst is asynchronous and active-high. Clock is clk, rising edge.
  - On reset: state IDLE; resp_valid=0, resp_data=0, resp_tag=0, div_a=0, div_b=0, div_enable=0; req_ready is 1 after reset.
  - Reset mid-operation returns to IDLE. The divider shares rst, so no drain is needed.
- States: IDLE, START, WAIT, RESP, DRAIN.
- req_ready=1 only in IDLE. Accept = req_valid & req_ready & ~flush; on the same cycle flush wins and the request is not taken.
- IDLE, on accept:
  - Latch op and tag.
  - Divisor zero: result = 0xFFFF_FFFF (DIV/DIVU) or req_a (REM/REMU); go RESP.
  - Signed op with a=0x8000_0000, b=0xFFFF_FFFF: result = 0x8000_0000 (DIV) or 0 (REM); go RESP.
  - Otherwise:
    - div_a = |a| for signed ops, else a.
    - div_b = |b| for signed ops, else b.
    - Record neg_q = sign(a)^sign(b) and neg_r = sign(a), both forced 0 for unsigned ops.
    - Go START.
- START: div_enable=1 (decode of state, exactly one cycle); go WAIT, or DRAIN if flush.
- div_a and div_b stay stable from START until leaving WAIT or DRAIN.
- WAIT:
  - div_enable=0.
  - On div_done: resp_data = neg_q ? -div_quot : div_quot (DIV/DIVU), or neg_r ? -div_rem : div_rem (REM/REMU); go RESP.
  - On flush, go DRAIN. If flush and div_done arrive together, flush wins and the controller goes to IDLE.
- DRAIN: wait for div_done, discard the result, go IDLE. req_ready stays 0 throughout.
- RESP:
  - resp_valid=1; resp_data and resp_tag held stable until resp_ready.
  - resp_valid & resp_ready → IDLE. resp_valid drops the next cycle, and a new request is accepted no earlier than that cycle.
  - flush in RESP → drop the result, go IDLE.
- Latency:
  - Special cases: resp_valid asserted in the cycle after accept.
  - Normal: resp_valid in the cycle after div_done. No dependency on exact divider latency (about 67 cycles at N=32).
- Only one request is outstanding; the controller is the sole driver of the divider.
- Arithmetic is two's complement modulo 2^N. Negation of 0x8000_0000 yields 0x8000_0000, which is correct as an unsigned magnitude.

Test Plan:
- DIVU a=100, b=7 → resp_data=14; REMU same operands → 2. div_enable high exactly one cycle, 1 cycle after accept.
- DIV a=0xFFFF_FFF9 (-7), b=2 → 0xFFFF_FFFD (-3); REM → 0xFFFF_FFFF (-1); REM a=7, b=-2 → 1.
- DIV 5/0 → 0xFFFF_FFFF; REM 5/0 → 5. Both arrive with resp_valid in the cycle after accept; div_enable never asserts.
- DIV 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000; REM same operands → 0; divider untouched.
- Flush during WAIT:
  - Expect no resp_valid and req_ready=0 until div_done is seen.
  - The next DIVU 100/7 then returns 14.
  - Also check flush coincident with req_valid in IDLE → no accept.
- resp_ready held low 3 cycles → resp_data and resp_tag stable, then one handshake.
- rst asserted mid-WAIT → all outputs 0 immediately, req_ready=1 after release.

Source files
------------

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: sequences RV32M divide/remainder requests through a shared unsigned multicycle divider
module div_seq_ctrl #(
  parameter int N = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [N-1:0]     req_a,
  input  logic [N-1:0]     req_b,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [N-1:0]     resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             div_enable,
  output logic [N-1:0]     div_a,
  output logic [N-1:0]     div_b,
  input  logic [N-1:0]     div_quot,
  input  logic [N-1:0]     div_rem,
  input  logic             div_done
);
  typedef enum logic [2:0] {IDLE, START, WAIT, RESP, DRAIN} state_t;
  state_t state, state_nx;
  logic accept, sgn, b_zero, ovf, is_rem, neg_q, neg_r;
  logic [N-1:0] abs_a, abs_b, min_int, fixed;
  assign min_int = {1'b1, {(N-1){1'b0}}};
  assign req_ready = state == IDLE;
  assign resp_valid = state == RESP;
  assign div_enable = state == START;
  assign accept = req_valid & req_ready & ~flush;
  assign sgn = ~req_op[0];
  assign b_zero = req_b == '0;
  assign ovf = sgn && req_a == min_int && req_b == '1;
  assign abs_a = (sgn && req_a[N-1]) ? -req_a : req_a;
  assign abs_b = (sgn && req_b[N-1]) ? -req_b : req_b;
  assign fixed = is_rem ? (neg_r ? -div_rem : div_rem) : (neg_q ? -div_quot : div_quot);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = accept ? ((b_zero || ovf) ? RESP : START) : IDLE;
      START: state_nx = flush ? DRAIN : WAIT;
      WAIT:  state_nx = flush ? (div_done ? IDLE : DRAIN) : (div_done ? RESP : WAIT);
      RESP:  state_nx = (flush || resp_ready) ? IDLE : RESP;
      DRAIN: state_nx = div_done ? IDLE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  // Special cases resolve at accept; divider operands only load on the normal path.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      is_rem <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      resp_tag <= '0;
      resp_data <= '0;
      div_a <= '0;
      div_b <= '0;
    end else begin
      if (accept) begin
        is_rem <= req_op[1];
        resp_tag <= req_tag;
        neg_q <= sgn & (req_a[N-1] ^ req_b[N-1]);
        neg_r <= sgn & req_a[N-1];
        if (b_zero) resp_data <= req_op[1] ? req_a : '1;
        else if (ovf) resp_data <= req_op[1] ? '0 : min_int;
        else begin
          div_a <= abs_a;
          div_b <= abs_b;
        end
      end
      if (state == WAIT && div_done && !flush) resp_data <= fixed;
    end
endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: directed plus randomized checks of div_seq_ctrl against an arithmetic reference model
module tb_div_seq_ctrl;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, flush = 0, resp_valid, resp_ready = 0;
  logic [1:0] req_op = 0;
  logic [31:0] req_a = 0, req_b = 0, resp_data, div_a, div_b, div_quot = 0, div_rem = 0;
  logic [4:0] req_tag = 0, resp_tag;
  logic div_enable, div_done = 0;
  int checks = 0, failures = 0;
  int cyc = 0, done_cyc = -10, done_cnt = 0, en_cnt = 0, cnt = 0, lat = 5;

  div_seq_ctrl #(.N(32), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag), .flush(flush), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .resp_tag(resp_tag), .div_enable(div_enable),
    .div_a(div_a), .div_b(div_b), .div_quot(div_quot), .div_rem(div_rem), .div_done(div_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Divider stand-in: fixed latency after the enable pulse, then a one-cycle done.
  always @(negedge clk) begin
    if (div_enable === 1'b1) en_cnt++;
    if (rst) begin
      cnt = 0;
      div_done = 0;
    end else begin
      div_done = 0;
      if (div_enable === 1'b1) cnt = lat;
      else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          div_done = 1;
          div_quot = (div_b == 0) ? '1 : div_a / div_b;
          div_rem = (div_b == 0) ? div_a : div_a % div_b;
          done_cyc = cyc;
          done_cnt++;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic rem;
    rem = op[1];
    if (b == 0) return rem ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'h0 : 32'h8000_0000;
      return rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    end
    return rem ? a % b : a / b;
  endfunction

  task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] exp;
    logic [4:0] tg;
    logic spc;
    int e0, k;
    exp = ref_div(op, a, b);
    spc = (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    tg = 5'($urandom);
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    e0 = en_cnt;
    req_valid = 1; req_op = op; req_a = a; req_b = b; req_tag = tg;
    @(posedge clk); #1;
    req_valid = 0; req_a = $urandom; req_b = $urandom; req_tag = 5'($urandom);
    if (spc) begin
      chk("special_resp_next_cycle", 64'(resp_valid), 64'd1);
      chk("special_no_enable", 64'(div_enable), 64'd0);
    end else begin
      chk("enable_after_accept", 64'(div_enable), 64'd1);
      chk("busy_not_ready", 64'(req_ready), 64'd0);
      k = 0;
      while (resp_valid !== 1'b1 && k < 300) begin
        @(posedge clk); #1;
        k++;
      end
      chk("resp_timeout", 64'(resp_valid), 64'd1);
      chk("resp_cycle_after_done", 64'(cyc), 64'(done_cyc + 1));
    end
    chk("resp_data", 64'(resp_data), 64'(exp));
    chk("resp_tag", 64'(resp_tag), 64'(tg));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 64'(resp_valid), 64'd1);
      chk("hold_data", 64'(resp_data), 64'(exp));
      chk("hold_tag", 64'(resp_tag), 64'(tg));
    end
    resp_ready = 1;
    @(posedge clk); #1;
    resp_ready = 0;
    chk("valid_drops", 64'(resp_valid), 64'd0);
    chk("ready_again", 64'(req_ready), 64'd1);
    chk("enable_count", 64'(en_cnt - e0), spc ? 64'd0 : 64'd1);
  endtask

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20)) - 32'd10;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int d0, k;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 64'(req_ready), 64'd1);
    chk("reset_valid", 64'(resp_valid), 64'd0);
    chk("reset_data", 64'(resp_data), 64'd0);
    chk("reset_tag", 64'(resp_tag), 64'd0);
    chk("reset_div_ab", {div_a, div_b}, 64'd0);
    chk("reset_enable", 64'(div_enable), 64'd0);
    rst = 0;
    @(posedge clk); #1;
    do_req(2'b01, 100, 7, 0);
    do_req(2'b11, 100, 7, 0);
    do_req(2'b00, 32'hFFFF_FFF9, 2, 0);
    do_req(2'b10, 32'hFFFF_FFF9, 2, 0);
    do_req(2'b10, 7, 32'hFFFF_FFFE, 0);
    do_req(2'b00, 5, 0, 0);
    do_req(2'b10, 5, 0, 0);
    do_req(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_req(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_req(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_req(2'b01, 12345, 67, 3);
    do_req(2'b10, 5, 0, 3);
    // flush while the divider is busy
    lat = 8;
    req_valid = 1; req_op = 2'b01; req_a = 100; req_b = 7;
    @(posedge clk); #1;
    req_valid = 0;
    @(posedge clk); #1;
    d0 = done_cnt;
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    k = 0;
    while (k < 100) begin
      @(posedge clk); #1;
      if (done_cnt > d0) break;
      chk("drain_no_valid", 64'(resp_valid), 64'd0);
      chk("drain_not_ready", 64'(req_ready), 64'd0);
      k++;
    end
    chk("drain_done_seen", 64'(done_cnt > d0), 64'd1);
    chk("drain_idle_ready", 64'(req_ready), 64'd1);
    chk("drain_no_resp", 64'(resp_valid), 64'd0);
    do_req(2'b01, 100, 7, 0);
    // flush beats a simultaneous request
    req_valid = 1; flush = 1; req_op = 2'b01; req_a = 100; req_b = 7;
    @(posedge clk); #1;
    req_valid = 0; flush = 0;
    chk("flush_blocks_accept_ready", 64'(req_ready), 64'd1);
    chk("flush_blocks_accept_en", 64'(div_enable), 64'd0);
    chk("flush_blocks_accept_valid", 64'(resp_valid), 64'd0);
    // reset in the middle of a divide
    req_valid = 1; req_op = 2'b01; req_a = 1000; req_b = 3; req_tag = 5'h1F;
    @(posedge clk); #1;
    req_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    #1;
    chk("midrst_valid", 64'(resp_valid), 64'd0);
    chk("midrst_data", 64'(resp_data), 64'd0);
    chk("midrst_tag", 64'(resp_tag), 64'd0);
    chk("midrst_div_ab", {div_a, div_b}, 64'd0);
    chk("midrst_enable", 64'(div_enable), 64'd0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    chk("midrst_ready_after", 64'(req_ready), 64'd1);
    for (int i = 0; i < 40; i++) begin
      lat = $urandom_range(3, 12);
      do_req(2'($urandom), pick($urandom_range(0, 6)), pick($urandom_range(0, 6)), $urandom_range(0, 2));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
